// File: rtl/conduit_csr_pkg.sv
// conduit_csr_pkg: register map offsets, FSM states and address decode helpers for conduit_csr_bank
package conduit_csr_pkg;
  localparam int CSR_DW = 32;
  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_IRQ_STAT = 12'h008;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH  = 12'h010;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} csr_state_e;
  typedef struct packed {
    logic       hit;
    logic       ro;
    logic [4:0] idx;
  } csr_dec_t;
  // idx is the word offset; only meaningful when hit is set
  function automatic csr_dec_t csr_decode(input logic [11:0] addr, input int unsigned n_scratch);
    logic [9:0] word;
    word = addr[11:2];
    csr_decode.hit = (addr[1:0] == 2'b00) && (word < OFF_SCRATCH[11:2] + 10'(n_scratch));
    csr_decode.ro  = word == OFF_STATUS[11:2];
    csr_decode.idx = word[4:0];
  endfunction
  function automatic logic [31:0] csr_lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction
endpackage

// File: rtl/csr_w1c_reg.sv
// csr_w1c_reg: write-1-to-clear status register where same-cycle hardware sets win over clears
module csr_w1c_reg #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_set,
  input  logic         i_clr_en,
  input  logic [N-1:0] i_clr,
  output logic [N-1:0] o_q
);
  logic [N-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else r_q <= i_set | (r_q & ~(i_clr_en ? i_clr : '0));
  end
  assign o_q = r_q;
endmodule

// File: rtl/conduit_csr_bank.sv
// conduit_csr_bank: CSR bank behind the APB conduit with wait states, W1C IRQ status and error responses
module conduit_csr_bank
  import conduit_csr_pkg::*;
#(
  parameter int D_WIDTH     = CSR_DW,
  parameter int N_SCRATCH   = 4,
  parameter int N_EVT       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   con_wr,
  input  logic                   con_rd,
  input  logic [11:0]            con_waddr,
  input  logic [11:0]            con_raddr,
  input  logic [D_WIDTH-1:0]     con_wdata,
  input  logic [D_WIDTH/8-1:0]   con_wbyte_enable,
  input  logic [D_WIDTH/8-1:0]   con_rbyte_enable,
  output logic                   con_wr_ack,
  output logic                   con_read_valid,
  output logic [D_WIDTH-1:0]     con_rdata,
  output logic                   con_slv_error,
  input  logic [D_WIDTH-1:0]     hw_status,
  input  logic [N_EVT-1:0]       hw_event,
  output logic [D_WIDTH-1:0]     ctrl,
  output logic                   irq
);
  csr_state_e           r_state;
  logic [3:0]           r_cnt;
  logic                 r_is_wr;
  logic                 r_err_pend;
  logic [11:0]          r_addr;
  logic [D_WIDTH-1:0]   r_wdata;
  logic [D_WIDTH/8-1:0] r_strb;
  logic                 r_wr_ack;
  logic                 r_read_valid;
  logic                 r_slv_error;
  logic                 r_irq;
  logic [D_WIDTH-1:0]   r_rdata;
  logic [D_WIDTH-1:0]   r_ctrl;
  logic [N_EVT-1:0]     r_irq_en;
  logic [D_WIDTH-1:0]   r_scratch [N_SCRATCH];
  logic                 w_idle;
  logic                 w_req;
  logic                 w_is_wr;
  logic [11:0]          w_addr;
  logic [D_WIDTH-1:0]   w_wdata;
  logic [D_WIDTH/8-1:0] w_strb;
  logic [D_WIDTH-1:0]   w_wmask;
  csr_dec_t             w_dec;
  logic                 w_err;
  logic                 w_fire;
  logic                 w_commit;
  logic [D_WIDTH-1:0]   w_rd_val;
  logic [N_EVT-1:0]     w_irq_stat;
  logic                 w_unused;
  // In IDLE the request is decoded straight from the inputs so a zero-wait access responds next cycle
  assign w_idle   = r_state == IDLE;
  assign w_req    = w_idle && (con_wr || con_rd);
  assign w_is_wr  = w_idle ? con_wr : r_is_wr;
  assign w_addr   = w_idle ? (con_wr ? con_waddr : con_raddr) : r_addr;
  assign w_wdata  = w_idle ? con_wdata : r_wdata;
  assign w_strb   = w_idle ? con_wbyte_enable : r_strb;
  assign w_wmask  = csr_lane_mask(w_strb);
  assign w_dec    = csr_decode(w_addr, N_SCRATCH);
  assign w_err    = !w_dec.hit || (w_is_wr && w_dec.ro);
  assign w_fire   = (w_req && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
  assign w_commit = w_fire && w_is_wr && !w_err;
  assign w_unused = ^con_rbyte_enable;
  always_comb begin
    w_rd_val = w_dec.idx == OFF_CTRL[6:2]     ? r_ctrl :
               w_dec.idx == OFF_STATUS[6:2]   ? hw_status :
               w_dec.idx == OFF_IRQ_STAT[6:2] ? D_WIDTH'(w_irq_stat) :
               w_dec.idx == OFF_IRQ_EN[6:2]   ? D_WIDTH'(r_irq_en) : '0;
    for (int i = 0; i < N_SCRATCH; i++)
      if (w_dec.idx == OFF_SCRATCH[6:2] + 5'(i)) w_rd_val = r_scratch[i];
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_err_pend   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_wr_ack     <= 1'b0;
      r_read_valid <= 1'b0;
      r_slv_error  <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_wr_ack     <= 1'b0;
      r_read_valid <= 1'b0;
      r_slv_error  <= 1'b0;
      if (w_req) begin
        r_is_wr <= con_wr;
        r_addr  <= w_addr;
        r_wdata <= con_wdata;
        r_strb  <= con_wbyte_enable;
        r_cnt   <= 4'(WAIT_CYCLES - 1);
      end
      if (w_fire) begin
        r_state      <= RESP;
        r_wr_ack     <= w_is_wr;
        r_read_valid <= !w_is_wr;
        r_err_pend   <= w_err;
        if (!w_is_wr) r_rdata <= w_err ? '0 : w_rd_val;
      end else if (w_req) r_state <= WAIT;
      else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      else if (r_state == RESP) begin
        r_state     <= r_err_pend ? ERR : IDLE;
        r_slv_error <= r_err_pend;
      end else r_state <= IDLE;
    end
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ctrl   <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
      for (int i = 0; i < N_SCRATCH; i++) r_scratch[i] <= '0;
    end else begin
      r_irq <= |(w_irq_stat & r_irq_en);
      if (w_commit && w_dec.idx == OFF_CTRL[6:2])
        r_ctrl <= (r_ctrl & ~w_wmask) | (w_wdata & w_wmask);
      if (w_commit && w_dec.idx == OFF_IRQ_EN[6:2])
        r_irq_en <= (r_irq_en & ~w_wmask[N_EVT-1:0]) | (w_wdata[N_EVT-1:0] & w_wmask[N_EVT-1:0]);
      for (int i = 0; i < N_SCRATCH; i++)
        if (w_commit && w_dec.idx == OFF_SCRATCH[6:2] + 5'(i))
          r_scratch[i] <= (r_scratch[i] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end
  csr_w1c_reg #(.N(N_EVT)) u_irq_stat (
    .i_clk    (pclk),
    .i_rst_n  (presetn),
    .i_set    (hw_event),
    .i_clr_en (w_commit && w_dec.idx == OFF_IRQ_STAT[6:2]),
    .i_clr    (w_wdata[N_EVT-1:0] & w_wmask[N_EVT-1:0]),
    .o_q      (w_irq_stat)
  );
  assign con_wr_ack     = r_wr_ack;
  assign con_read_valid = r_read_valid;
  assign con_rdata      = r_rdata;
  assign con_slv_error  = r_slv_error;
  assign ctrl           = r_ctrl;
  assign irq            = r_irq;
endmodule
